// File: rtl/act_share_arb.sv
// Round-robin arbiter sharing one activation unit among NREQ requesters; one job in flight.
// Accept -> act_start next cycle, act_valid -> rsp pulse next cycle; req_ready only while IDLE.
module act_share_arb #(
  parameter int DWIDTH  = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_x,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_y,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     act_start,
  output logic [DWIDTH-1:0]        act_x,
  input  logic [DWIDTH-1:0]        act_y,
  input  logic                     act_valid
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      grant_q;
  logic [CW-1:0]       cnt_q;
  logic [DWIDTH-1:0]   act_x_q;
  logic [DWIDTH-1:0]   rsp_y_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic                rsp_err_q;

  logic [IDW-1:0]      pick_idx;
  logic [IDW-1:0]      scan_idx;
  logic                pick_vld;
  logic                accept;
  logic                timeout_hit;

  // Scan from farthest to nearest so the requester right after ptr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign accept      = |(req_valid & req_ready);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (act_valid || timeout_hit) state_d = DRAIN;
      DRAIN:   if (!act_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_start = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    req_ready = '0;
    if (state_q == IDLE && pick_vld && rst) req_ready = NREQ'(1) << pick_idx;
  end

  // A normal result on the final ISSUE edge wins over the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= IDW'(NREQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      act_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        act_x_q <= req_x[pick_idx*DWIDTH +: DWIDTH];
        grant_q <= pick_idx;
        ptr_q   <= pick_idx;
        cnt_q   <= '0;
      end
      if (state_q == ISSUE) begin
        if (act_valid) begin
          rsp_y_q     <= act_y;
          rsp_valid_q <= NREQ'(1) << grant_q;
        end else if (timeout_hit) begin
          rsp_y_q     <= '0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= NREQ'(1) << grant_q;
        end
        if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign act_x     = act_x_q;
  assign grant_id  = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_act_share_arb.sv
// Bench for act_share_arb: transaction-level reference model plus directed and random traffic.
module tb_act_share_arb;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 64;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_x = '0;
  logic [DW-1:0]    act_y = '0;
  logic             act_valid = 1'b0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_y, act_x;
  logic             rsp_err, busy, act_start;
  logic [1:0]       grant_id;

  always #5 clk = ~clk;

  act_share_arb #(.DWIDTH(DW), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .grant_id(grant_id), .act_start(act_start), .act_x(act_x),
    .act_y(act_y), .act_valid(act_valid)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (((v >> j) & NR'(1)) != '0) return j;
    end
    return -1;
  endfunction

  // Reference model: which requester is being served and what it has been told so far.
  int            m_mode = M_IDLE, m_last = NR - 1, m_gid = 0, m_age = 0;
  logic [DW-1:0] m_opnd = '0, m_y = '0;
  logic [NR-1:0] m_pulse = '0;
  logic          m_err = 1'b0;

  always @(posedge clk) begin
    int g;
    m_pulse = '0;
    m_err   = 1'b0;
    if (!rst) begin
      m_mode = M_IDLE; m_last = NR - 1; m_gid = 0; m_age = 0; m_opnd = '0; m_y = '0;
    end else if (m_mode == M_IDLE) begin
      g = rr_pick(req_valid, m_last);
      if (g >= 0) begin
        m_gid = g; m_last = g; m_opnd = req_x[g*DW +: DW]; m_age = 0; m_mode = M_ISSUE;
      end
    end else if (m_mode == M_ISSUE) begin
      if (act_valid) begin
        m_y = act_y; m_pulse = NR'(1) << m_gid; m_mode = M_DRAIN;
      end else if (m_age == TO - 1) begin
        m_y = '0; m_err = 1'b1; m_pulse = NR'(1) << m_gid; m_mode = M_DRAIN;
      end else m_age++;
    end else if (!act_valid) m_mode = M_IDLE;
  end

  int            cyc = 0, start_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, drain_cnt = 0;
  logic          prev_start = 1'b0;
  logic [NR-1:0] acc_mask = '0, last_vld = '0;
  logic [DW-1:0] last_y = '0;
  logic          last_err = 1'b0;
  int            grants[$];

  always @(negedge clk) begin
    logic [NR-1:0] e_rdy, e_vld;
    logic [DW-1:0] e_x, e_y;
    logic          e_start, e_busy, e_err;
    int            e_gid, p;
    cyc++;
    e_rdy = '0; e_vld = '0; e_x = '0; e_y = '0;
    e_start = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_gid = 0;
    if (rst) begin
      p = rr_pick(req_valid, m_last);
      if (m_mode == M_IDLE && p >= 0) e_rdy = NR'(1) << p;
      e_start = (m_mode == M_ISSUE);
      e_busy  = (m_mode != M_IDLE);
      e_x = m_opnd; e_vld = m_pulse; e_y = m_y; e_err = m_err; e_gid = m_gid;
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("act_start", 64'(act_start), 64'(e_start));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("act_x", 64'(act_x), 64'(e_x));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_vld));
    chk("rsp_y", 64'(rsp_y), 64'(e_y));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("grant_id", 64'(grant_id), 64'(e_gid));
    acc_mask = req_valid & req_ready;
    for (int i = 0; i < NR; i++) if (acc_mask[i]) grants.push_back(i);
    if (act_start && !prev_start) start_cyc = cyc;
    prev_start = act_start;
    if (|rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; last_vld = rsp_valid; last_y = rsp_y; last_err = rsp_err;
    end
    if (busy && !act_start) drain_cnt++;
  end

  // Stimulus state: activation-unit responder and random requesters.
  bit            rand_mode = 0, fixed_y_en = 0;
  logic [DW-1:0] fixed_y = '0;
  int            cur_lat = 3, cur_hold = 1, rc = 0, hl = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) begin
      act_valid = 1'b0; rc = 0; hl = 0;
    end else if (hl > 0) begin
      hl--;
      if (hl == 0) act_valid = 1'b0;
    end else begin
      act_valid = 1'b0;
      if (act_start) begin
        if (rc == 0 && rand_mode) begin
          cur_lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
          cur_hold = int'($urandom_range(1, 4));
        end
        rc++;
        if (cur_lat > 0 && rc == cur_lat) begin
          act_valid = 1'b1; act_y = fixed_y_en ? fixed_y : DW'($urandom); hl = cur_hold; rc = 0;
        end
      end else rc = 0;
    end
    req_valid = req_valid & ~acc_mask;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_x[i*DW +: DW] = DW'($urandom); req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy || |req_valid); i++) step();
    chk("wait idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n0, gb, d0;
    repeat (3) step();
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset grant_id", 64'(grant_id), 64'd0);
    chk("reset act_start", 64'(act_start), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b1;

    // Single request from requester 2, 12-cycle activation latency.
    fixed_y_en = 1; fixed_y = 32'h3F00_0000; cur_lat = 12; cur_hold = 1;
    n0 = rsp_cnt; req_valid = 4'b0100;
    for (int i = 0; i < 100 && rsp_cnt == n0; i++) step();
    chk("single rsp count", 64'(rsp_cnt), 64'(n0 + 1));
    chk("single rsp_valid", 64'(last_vld), 64'h4);
    chk("single rsp_y", 64'(last_y), 64'h3F00_0000);
    chk("single rsp_err", 64'(last_err), 64'd0);
    chk("single latency", 64'(rsp_cyc - start_cyc), 64'd12);
    chk("single busy after drain", 64'(busy), 64'd0);
    fixed_y_en = 0; cur_lat = 3;

    // All four together after reset: 0,1,2,3.
    rst = 1'b0; step(); rst = 1'b1;
    gb = grants.size(); req_valid = 4'b1111;
    for (int i = 0; i < 200 && grants.size() < gb + 4; i++) step();
    chk("all4 grant count", 64'(grants.size()), 64'(gb + 4));
    if (grants.size() >= gb + 4)
      for (int k = 0; k < 4; k++) chk("all4 order", 64'(grants[gb+k]), 64'(k));
    wait_idle();

    // Pointer at 3: serve 1, then 0 and 3 pending -> 3 before 0.
    gb = grants.size(); req_valid = 4'b0010;
    for (int i = 0; i < 50 && grants.size() < gb + 1; i++) step();
    req_valid = req_valid | 4'b1001;
    for (int i = 0; i < 200 && grants.size() < gb + 3; i++) step();
    chk("rr grant count", 64'(grants.size()), 64'(gb + 3));
    if (grants.size() >= gb + 3) begin
      chk("rr first", 64'(grants[gb]), 64'd1);
      chk("rr second", 64'(grants[gb+1]), 64'd3);
      chk("rr third", 64'(grants[gb+2]), 64'd0);
    end
    wait_idle();

    // Activation unit never answers.
    cur_lat = 0; n0 = rsp_cnt; req_valid = 4'b0010;
    for (int i = 0; i < 200 && rsp_cnt == n0; i++) step();
    chk("timeout rsp count", 64'(rsp_cnt), 64'(n0 + 1));
    chk("timeout latency", 64'(rsp_cyc - start_cyc), 64'd64);
    chk("timeout rsp_err", 64'(last_err), 64'd1);
    chk("timeout rsp_y", 64'(last_y), 64'd0);
    chk("timeout rsp_valid", 64'(last_vld), 64'h2);
    wait_idle();

    // act_valid high for the result cycle plus five more: six DRAIN cycles, one pulse.
    cur_lat = 3; cur_hold = 6; d0 = drain_cnt; n0 = rsp_cnt; req_valid = 4'b0001;
    wait_idle();
    chk("hold drain cycles", 64'(drain_cnt - d0), 64'd6);
    chk("hold single pulse", 64'(rsp_cnt - n0), 64'd1);
    cur_hold = 1;

    // Reset in the middle of ISSUE while requester 0 waits.
    cur_lat = 0; req_x[2*DW +: DW] = 32'hDEAD_BEEF; gb = grants.size(); req_valid = 4'b0100;
    for (int i = 0; i < 50 && grants.size() < gb + 1; i++) step();
    req_valid = req_valid | 4'b0001;
    repeat (5) step();
    chk("pre-reset act_start", 64'(act_start), 64'd1);
    chk("pre-reset act_x", 64'(act_x), 64'hDEAD_BEEF);
    n0 = rsp_cnt;
    #2 rst = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset act_start", 64'(act_start), 64'd0);
    chk("async reset act_x", 64'(act_x), 64'd0);
    chk("async reset grant_id", 64'(grant_id), 64'd0);
    step(); step();
    rst = 1'b1;
    gb = grants.size();
    for (int i = 0; i < 20 && grants.size() < gb + 1; i++) step();
    chk("post-reset grant count", 64'(grants.size()), 64'(gb + 1));
    if (grants.size() >= gb + 1) chk("post-reset grant", 64'(grants[gb]), 64'd0);
    chk("no pulse from aborted job", 64'(rsp_cnt), 64'(n0));
    cur_lat = 3;
    wait_idle();

    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
